// File: rtl/riscv_alu_arbiter_pkg.sv
// riscv_alu_arbiter_pkg: shared ALU defines, arbiter FSM state type and ctrl-code helpers.
// The XLEN / ALU_CTRL_* defines are the shared riscv_configs set. They sit behind that
// file's include guard so a real riscv_configs.v in the same build does not clash.
`ifndef RISCV_CONFIGS_V
`define RISCV_CONFIGS_V
`define XLEN           32
`define ALU_CTRL_ADD   4'b0000
`define ALU_CTRL_SLL   4'b0001
`define ALU_CTRL_SLT   4'b0010
`define ALU_CTRL_SLTU  4'b0011
`define ALU_CTRL_XOR   4'b0100
`define ALU_CTRL_SRL   4'b0101
`define ALU_CTRL_OR    4'b0110
`define ALU_CTRL_AND   4'b0111
`define ALU_CTRL_SUB   4'b1000
`define ALU_CTRL_SRA   4'b1101
`define ALU_CTRL_VALID(c) (((c) == `ALU_CTRL_ADD) || ((c) == `ALU_CTRL_SLL) || \
                           ((c) == `ALU_CTRL_SLT) || ((c) == `ALU_CTRL_SLTU) || \
                           ((c) == `ALU_CTRL_XOR) || ((c) == `ALU_CTRL_SRL) || \
                           ((c) == `ALU_CTRL_OR)  || ((c) == `ALU_CTRL_AND) || \
                           ((c) == `ALU_CTRL_SUB) || ((c) == `ALU_CTRL_SRA))
`endif

package riscv_alu_arbiter_pkg;

    localparam int XLEN    = `XLEN;
    localparam int SHAMT_W = $clog2(XLEN);

    localparam logic [3:0] ALU_OP_ADD  = `ALU_CTRL_ADD;
    localparam logic [3:0] ALU_OP_SLL  = `ALU_CTRL_SLL;
    localparam logic [3:0] ALU_OP_SLT  = `ALU_CTRL_SLT;
    localparam logic [3:0] ALU_OP_SLTU = `ALU_CTRL_SLTU;
    localparam logic [3:0] ALU_OP_XOR  = `ALU_CTRL_XOR;
    localparam logic [3:0] ALU_OP_SRL  = `ALU_CTRL_SRL;
    localparam logic [3:0] ALU_OP_OR   = `ALU_CTRL_OR;
    localparam logic [3:0] ALU_OP_AND  = `ALU_CTRL_AND;
    localparam logic [3:0] ALU_OP_SUB  = `ALU_CTRL_SUB;
    localparam logic [3:0] ALU_OP_SRA  = `ALU_CTRL_SRA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // True when ctrl is one of the ten defined ALU operations.
    function automatic logic alu_ctrl_valid(input logic [3:0] ctrl);
        return `ALU_CTRL_VALID(ctrl);
    endfunction

endpackage

// File: rtl/riscv_alu_arbiter_alu.sv
// riscv_alu: purely combinational RV32 integer ALU; undefined ctrl codes yield zero.
module riscv_alu
    import riscv_alu_arbiter_pkg::*;
(
    input  logic [XLEN-1:0] i_alu_a,
    input  logic [XLEN-1:0] i_alu_b,
    input  logic [3:0]      i_alu_ctrl,
    output logic [XLEN-1:0] o_alu_result,
    output logic            o_alu_zero
);

    logic [SHAMT_W-1:0] w_shamt;

    assign w_shamt = i_alu_b[SHAMT_W-1:0];

    // Operation select; undefined codes fall to a known zero so nothing downstream sees X.
    always_comb begin
        o_alu_result = {XLEN{1'b0}};
        case (i_alu_ctrl)
            ALU_OP_ADD:  o_alu_result = i_alu_a + i_alu_b;
            ALU_OP_SUB:  o_alu_result = i_alu_a - i_alu_b;
            ALU_OP_SLL:  o_alu_result = i_alu_a << w_shamt;
            ALU_OP_SLT:  o_alu_result = {{(XLEN-1){1'b0}}, ($signed(i_alu_a) < $signed(i_alu_b))};
            ALU_OP_SLTU: o_alu_result = {{(XLEN-1){1'b0}}, (i_alu_a < i_alu_b)};
            ALU_OP_XOR:  o_alu_result = i_alu_a ^ i_alu_b;
            ALU_OP_SRL:  o_alu_result = i_alu_a >> w_shamt;
            ALU_OP_SRA:  o_alu_result = XLEN'($signed(i_alu_a) >>> w_shamt);
            ALU_OP_OR:   o_alu_result = i_alu_a | i_alu_b;
            ALU_OP_AND:  o_alu_result = i_alu_a & i_alu_b;
            default:     o_alu_result = {XLEN{1'b0}};
        endcase
    end

    assign o_alu_zero = (o_alu_result == {XLEN{1'b0}});

endmodule

// File: rtl/riscv_alu_arbiter.sv
// riscv_alu_arbiter: round-robin share of one riscv_alu between NUM_REQ requesters.
// One op in flight; IDLE grants and captures, EXEC registers the response, RESP holds it
// until the owner accepts. ALU inputs come only from the op registers.
module riscv_alu_arbiter
    import riscv_alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    output logic [NUM_REQ-1:0]      o_req_ready,
    input  logic [NUM_REQ*XLEN-1:0] i_req_a,
    input  logic [NUM_REQ*XLEN-1:0] i_req_b,
    input  logic [NUM_REQ*4-1:0]    i_req_ctrl,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [ID_W-1:0]         o_rsp_id,
    output logic [XLEN-1:0]         o_rsp_result,
    output logic                    o_rsp_zero,
    output logic                    o_rsp_err,
    output logic                    o_busy
);

    arb_state_e      r_state;
    arb_state_e      w_state_next;
    logic [ID_W-1:0] r_last_grant;

    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic [3:0]      r_op_ctrl;
    logic [ID_W-1:0] r_op_id;

    logic            r_rsp_valid;
    logic [ID_W-1:0] r_rsp_id;
    logic [XLEN-1:0] r_rsp_result;
    logic            r_rsp_zero;
    logic            r_rsp_err;

    logic            w_grant_found;
    logic [ID_W-1:0] w_grant_id;
    logic            w_accept;
    logic [XLEN-1:0] w_sel_a;
    logic [XLEN-1:0] w_sel_b;
    logic [3:0]      w_sel_ctrl;

    logic [XLEN-1:0] w_alu_result;
    logic            w_op_err;
    logic [XLEN-1:0] w_clean_result;

    // Round-robin search starting one past the last grant, wrapping around.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = {ID_W{1'b0}};
        for (int i = 1; i <= NUM_REQ; i++) begin
            logic [ID_W-1:0] scan_id;
            logic            hit;
            scan_id       = ID_W'((int'(r_last_grant) + i) % NUM_REQ);
            hit           = !w_grant_found && i_req_valid[scan_id];
            w_grant_id    = hit ? scan_id : w_grant_id;
            w_grant_found = w_grant_found | i_req_valid[scan_id];
        end
    end

    // Operand mux for the granted requester's slices.
    always_comb begin
        w_sel_a    = {XLEN{1'b0}};
        w_sel_b    = {XLEN{1'b0}};
        w_sel_ctrl = 4'b0000;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sel_a    = (w_grant_id == ID_W'(k)) ? i_req_a[k*XLEN +: XLEN] : w_sel_a;
            w_sel_b    = (w_grant_id == ID_W'(k)) ? i_req_b[k*XLEN +: XLEN] : w_sel_b;
            w_sel_ctrl = (w_grant_id == ID_W'(k)) ? i_req_ctrl[k*4 +: 4]    : w_sel_ctrl;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: w_state_next = w_accept ? ST_EXEC : ST_IDLE;
            ST_EXEC: w_state_next = ST_RESP;
            ST_RESP: w_state_next = i_rsp_ready ? ST_IDLE : ST_RESP;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: same-cycle one-hot ready in IDLE, busy outside IDLE.
    always_comb begin
        o_req_ready = {NUM_REQ{1'b0}};
        w_accept    = 1'b0;
        o_busy      = (r_state != ST_IDLE);
        if ((r_state == ST_IDLE) && w_grant_found && !i_rst) begin
            w_accept                = 1'b1;
            o_req_ready[w_grant_id] = 1'b1;
        end else begin
            w_accept = 1'b0;
        end
    end

    // Op capture on grant; these registers are the only source of ALU inputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op_a       <= {XLEN{1'b0}};
            r_op_b       <= {XLEN{1'b0}};
            r_op_ctrl    <= 4'b0000;
            r_op_id      <= {ID_W{1'b0}};
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_op_a       <= w_sel_a;
            r_op_b       <= w_sel_b;
            r_op_ctrl    <= w_sel_ctrl;
            r_op_id      <= w_grant_id;
            r_last_grant <= w_grant_id;
        end
    end

    riscv_alu u_alu (
        .i_alu_a      (r_op_a),
        .i_alu_b      (r_op_b),
        .i_alu_ctrl   (r_op_ctrl),
        .o_alu_result (w_alu_result),
        .o_alu_zero   ()
    );

    // Undefined ctrl codes return zero with err set; zero flag follows the cleaned result.
    assign w_op_err       = !alu_ctrl_valid(r_op_ctrl);
    assign w_clean_result = w_op_err ? {XLEN{1'b0}} : w_alu_result;

    // Response registers: loaded in EXEC, held through RESP until the handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= {ID_W{1'b0}};
            r_rsp_result <= {XLEN{1'b0}};
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_EXEC: begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_id     <= r_op_id;
                    r_rsp_result <= w_clean_result;
                    r_rsp_zero   <= (w_clean_result == {XLEN{1'b0}});
                    r_rsp_err    <= w_op_err;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= r_rsp_valid;
                end
            endcase
        end
    end

    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_zero   = r_rsp_zero;
    assign o_rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// tb_riscv_alu_arbiter: directed checks of the shared-ALU arbiter with 2 and 3 requesters.
module tb_riscv_alu_arbiter;

    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SLT  = 4'b0010;
    localparam logic [3:0] C_SLTU = 4'b0011;
    localparam logic [3:0] C_OR   = 4'b0110;
    localparam logic [3:0] C_AND  = 4'b0111;
    localparam logic [3:0] C_SUB  = 4'b1000;
    localparam logic [3:0] C_SRA  = 4'b1101;
    localparam logic [3:0] C_BAD  = 4'b1111;

    logic        clk;
    logic        rst;

    logic [1:0]  valid2, ready2;
    logic [63:0] a2, b2;
    logic [7:0]  ctrl2;
    logic        rsp_valid2, rsp_ready2, rsp_id2, zero2, err2, busy2;
    logic [31:0] result2;

    logic [2:0]  valid3, ready3;
    logic [95:0] a3, b3;
    logic [11:0] ctrl3;
    logic        rsp_valid3, rsp_ready3, zero3, err3, busy3;
    logic [1:0]  rsp_id3;
    logic [31:0] result3;

    int n_checks = 0;
    int n_pass   = 0;

    riscv_alu_arbiter #(.NUM_REQ(2)) dut2 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(valid2), .o_req_ready(ready2),
        .i_req_a(a2), .i_req_b(b2), .i_req_ctrl(ctrl2),
        .o_rsp_valid(rsp_valid2), .i_rsp_ready(rsp_ready2), .o_rsp_id(rsp_id2),
        .o_rsp_result(result2), .o_rsp_zero(zero2), .o_rsp_err(err2), .o_busy(busy2)
    );

    riscv_alu_arbiter #(.NUM_REQ(3)) dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(valid3), .o_req_ready(ready3),
        .i_req_a(a3), .i_req_b(b3), .i_req_ctrl(ctrl3),
        .o_rsp_valid(rsp_valid3), .i_rsp_ready(rsp_ready3), .o_rsp_id(rsp_id3),
        .o_rsp_result(result3), .o_rsp_zero(zero3), .o_rsp_err(err3), .o_busy(busy3)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req2(input int k, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        a2[k*32 +: 32] = a;
        b2[k*32 +: 32] = b;
        ctrl2[k*4 +: 4] = c;
    endtask

    task automatic set_req3(input int k, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        a3[k*32 +: 32] = a;
        b3[k*32 +: 32] = b;
        ctrl3[k*4 +: 4] = c;
    endtask

    task automatic wait_rsp2(input string tag);
        int c;
        c = 0;
        while (!rsp_valid2 && c < 10) begin
            tick();
            c++;
        end
        check(tag, 32'(rsp_valid2), 32'd1);
    endtask

    task automatic handshake2();
        rsp_ready2 = 1'b1;
        tick();
        rsp_ready2 = 1'b0;
    endtask

    initial begin
        logic [31:0] exp2 [2];
        logic [31:0] exp3 [3];
        int cnt3 [3];
        int n;
        logic hold_ok;
        logic seen_rsp;

        clk = 1'b0; rst = 1'b1;
        valid2 = 2'b00; a2 = 64'd0; b2 = 64'd0; ctrl2 = 8'd0; rsp_ready2 = 1'b0;
        valid3 = 3'b000; a3 = 96'd0; b3 = 96'd0; ctrl3 = 12'd0; rsp_ready3 = 1'b0;
        tick();
        tick();
        check("rst_ready",  32'(ready2), 32'd0);
        check("rst_valid",  32'(rsp_valid2), 32'd0);
        check("rst_id",     32'(rsp_id2), 32'd0);
        check("rst_result", result2, 32'd0);
        check("rst_zero",   32'(zero2), 32'd0);
        check("rst_err",    32'(err2), 32'd0);
        check("rst_busy",   32'(busy2), 32'd0);
        rst = 1'b0;

        // 1) single ADD, latency T -> T+2
        set_req2(0, C_ADD, 32'd5, 32'd7);
        valid2 = 2'b01;
        #1;
        check("t1_ready", 32'(ready2), 32'd1);
        tick();
        valid2 = 2'b00;
        check("t1_busy_exec", 32'(busy2), 32'd1);
        check("t1_no_rsp_t1", 32'(rsp_valid2), 32'd0);
        tick();
        check("t1_rsp_t2", 32'(rsp_valid2), 32'd1);
        check("t1_id",     32'(rsp_id2), 32'd0);
        check("t1_result", result2, 32'd12);
        check("t1_zero",   32'(zero2), 32'd0);
        check("t1_err",    32'(err2), 32'd0);
        handshake2();
        check("t1_done_valid", 32'(rsp_valid2), 32'd0);
        check("t1_done_busy",  32'(busy2), 32'd0);

        // 2) both valid every cycle, alternating grants from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req2(0, C_ADD, 32'd1, 32'd2);
        set_req2(1, C_SUB, 32'd3, 32'd3);
        exp2[0] = 32'd3;
        exp2[1] = 32'd0;
        valid2 = 2'b11;
        rsp_ready2 = 1'b1;
        #1;
        check("t2_first_ready", 32'(ready2), 32'd1);
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            tick();
            if (rsp_valid2) begin
                check("t2_id",     32'(rsp_id2), 32'(n % 2));
                check("t2_result", result2, exp2[n % 2]);
                check("t2_zero",   32'(zero2), (n % 2 == 1) ? 32'd1 : 32'd0);
                n++;
            end
        end
        valid2 = 2'b00;
        check("t2_count", 32'(n), 32'd4);
        tick();
        rsp_ready2 = 1'b0;

        // 3) SRA under backpressure; req1 waits with an illegal ctrl code
        set_req2(0, C_SRA, 32'h8000_0000, 32'd4);
        set_req2(1, C_BAD, 32'h0000_1234, 32'h0000_5678);
        valid2 = 2'b11;
        #1;
        check("t3_ready", 32'(ready2), 32'd1);
        tick();
        valid2 = 2'b10;
        wait_rsp2("t3_wait");
        check("t3_result", result2, 32'hF800_0000);
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            hold_ok = hold_ok & rsp_valid2 & (result2 == 32'hF800_0000) & (ready2 == 2'b00) & busy2;
        end
        check("t3_hold", 32'(hold_ok), 32'd1);
        rsp_ready2 = 1'b1;
        tick();
        rsp_ready2 = 1'b0;
        check("t3_idle_busy", 32'(busy2), 32'd0);
        check("t3_next_ready", 32'(ready2), 32'd2);

        // 4) illegal ctrl on req1, then a legal op
        tick();
        valid2 = 2'b00;
        wait_rsp2("t4_wait");
        check("t4_id",     32'(rsp_id2), 32'd1);
        check("t4_err",    32'(err2), 32'd1);
        check("t4_result", result2, 32'd0);
        check("t4_zero",   32'(zero2), 32'd1);
        handshake2();
        set_req2(0, C_OR, 32'h0000_00F0, 32'h0000_000F);
        valid2 = 2'b01;
        #1;
        check("t4b_ready", 32'(ready2), 32'd1);
        tick();
        valid2 = 2'b00;
        wait_rsp2("t4b_wait");
        check("t4b_err",    32'(err2), 32'd0);
        check("t4b_result", result2, 32'h0000_00FF);
        check("t4b_zero",   32'(zero2), 32'd0);
        handshake2();

        // 5) reset while an op sits in EXEC
        set_req2(0, C_ADD, 32'd10, 32'd20);
        valid2 = 2'b01;
        #1;
        check("t5_ready", 32'(ready2), 32'd1);
        tick();
        valid2 = 2'b00;
        check("t5_in_exec", 32'(busy2), 32'd1);
        rst = 1'b1;
        tick();
        check("t5_rst_busy", 32'(busy2), 32'd0);
        rst = 1'b0;
        seen_rsp = rsp_valid2;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen_rsp = seen_rsp | rsp_valid2;
        end
        check("t5_no_rsp", 32'(seen_rsp), 32'd0);
        set_req2(1, C_ADD, 32'd1, 32'd1);
        valid2 = 2'b11;
        #1;
        check("t5_tie_req0", 32'(ready2), 32'd1);
        tick();
        valid2 = 2'b00;
        wait_rsp2("t5_wait");
        check("t5_id",     32'(rsp_id2), 32'd0);
        check("t5_result", result2, 32'd30);
        handshake2();

        // 6) three requesters, nine ops, strict rotation
        set_req3(0, C_SLT,  32'hFFFF_FFFF, 32'd1);
        set_req3(1, C_SLTU, 32'hFFFF_FFFF, 32'd1);
        set_req3(2, C_AND,  32'h0000_F0F0, 32'h0000_FF00);
        exp3[0] = 32'd1;
        exp3[1] = 32'd0;
        exp3[2] = 32'h0000_F000;
        cnt3[0] = 0; cnt3[1] = 0; cnt3[2] = 0;
        valid3 = 3'b111;
        rsp_ready3 = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 60 && n < 9; cyc++) begin
            tick();
            if (rsp_valid3) begin
                check("t6_id",     32'(rsp_id3), 32'(n % 3));
                check("t6_result", result3, exp3[n % 3]);
                cnt3[rsp_id3 % 3]++;
                n++;
            end
        end
        valid3 = 3'b000;
        check("t6_count", 32'(n), 32'd9);
        check("t6_cnt0", 32'(cnt3[0]), 32'd3);
        check("t6_cnt1", 32'(cnt3[1]), 32'd3);
        check("t6_cnt2", 32'(cnt3[2]), 32'd3);
        tick();
        rsp_ready3 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
